// File: rtl/spi_master_ctrl_if.sv
// Command/response bus of the SPI master controller.
// The issuer of commands uses the master modport; the controller uses the slave modport.
interface spi_master_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// Command-driven SPI master: one accepted command becomes one 11-bit slave frame, read-data frames return the MISO byte.
// Optional macro SPIM_SEQ_CHECK_EN rejects a read-data command issued before any read-address frame.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// START   | SS_n low, MOSI 0, slave detects select
// SHIFT   | 11 frame bits driven MSB first
// WAIT    | MISO_LAT turnaround cycles before the reply
// CAPTURE | 8 MISO samples, MSB first
// GAP     | SS_n high for GAP cycles
module spi_master_ctrl #(
    parameter int unsigned MISO_LAT = 2,
    parameter int unsigned GAP      = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_master_ctrl_if.slave   cmd,
    output logic               SS_n,
    output logic               MOSI,
    input  logic               MISO
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_SHIFT, S_WAIT, S_CAPTURE, S_GAP
    } state_t;

    state_t      state, next_state;
    logic [3:0]  cnt, cnt_d;
    logic [10:0] frame_q;
    logic [1:0]  op_q;
    logic [7:0]  shreg;
    logic [7:0]  capture_byte;
    logic        ready_q, ready_d;
    logic        ss_n_q, ss_n_d;
    logic        mosi_q, mosi_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        accept;
    logic        reject;
    logic        done;

    assign accept = cmd.cmd_valid && ready_q;

`ifdef SPIM_SEQ_CHECK_EN
    logic rd_addr_seen;
    logic rsp_err_q;

    assign reject = accept && (cmd.cmd_op == 2'b11) && !rd_addr_seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_seen <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (done && (op_q == 2'b10))
                rd_addr_seen <= 1'b1;
            if (rsp_valid_d)
                rsp_err_q <= reject;
        end
    end

    assign cmd.rsp_err = rsp_err_q;
`else
    assign reject      = 1'b0;
    assign cmd.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            frame_q     <= 11'd0;
            op_q        <= 2'b00;
            shreg       <= 8'h00;
            ready_q     <= 1'b0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            state       <= next_state;
            cnt         <= cnt_d;
            ready_q     <= ready_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            if (accept) begin
                frame_q <= {cmd.cmd_op[1], cmd.cmd_op, cmd.cmd_data};
                op_q    <= cmd.cmd_op;
            end else if (next_state == S_SHIFT) begin
                frame_q <= {frame_q[9:0], 1'b0};
            end
            if (state == S_CAPTURE)
                shreg <= capture_byte;
            if (rsp_valid_d)
                rsp_data_q <= rsp_data_d;
        end
    end

    // Timers are down-counters loaded with (length - 1) on state entry.
    always_comb begin
        next_state = state;
        cnt_d      = cnt;
        case (state)
            S_IDLE: begin
                if (accept && !reject)
                    next_state = S_START;
            end
            S_START: begin
                next_state = S_SHIFT;
                cnt_d      = 4'd10;
            end
            S_SHIFT: begin
                if (cnt == 4'd0) begin
                    if (op_q == 2'b11) begin
                        next_state = S_WAIT;
                        cnt_d      = 4'(MISO_LAT - 1);
                    end else begin
                        next_state = S_GAP;
                        cnt_d      = 4'(GAP - 1);
                    end
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    next_state = S_CAPTURE;
                    cnt_d      = 4'd7;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            S_CAPTURE: begin
                if (cnt == 4'd0) begin
                    next_state = S_GAP;
                    cnt_d      = 4'(GAP - 1);
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            S_GAP: begin
                if (cnt == 4'd0)
                    next_state = S_IDLE;
                else
                    cnt_d = cnt - 4'd1;
            end
            default: begin
                next_state = S_IDLE;
                cnt_d      = 4'd0;
            end
        endcase
    end

    // Outputs are registered from next_state so pins change on the same edge as the state.
    always_comb begin
        ss_n_d       = (next_state == S_IDLE) || (next_state == S_GAP);
        mosi_d       = (next_state == S_SHIFT) ? frame_q[10] : 1'b0;
        ready_d      = (next_state == S_IDLE) && !accept;
        done         = (next_state == S_GAP) && (state != S_GAP);
        rsp_valid_d  = done || reject;
        capture_byte = {shreg[6:0], MISO};
        rsp_data_d   = (state == S_CAPTURE) ? capture_byte : 8'h00;
    end

    assign SS_n          = ss_n_q;
    assign MOSI          = mosi_q;
    assign cmd.cmd_ready = ready_q;
    assign cmd.rsp_valid = rsp_valid_q;
    assign cmd.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural SPI slave + RAM model.
// Build with SPIM_SEQ_CHECK_EN defined to exercise the read-sequence check.
module tb_spi_master_ctrl;
    localparam int LAT = 2;
    localparam int GP  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic MISO  = 1'b0;
    logic SS_n;
    logic MOSI;

    spi_master_ctrl_if bus ();

    spi_master_ctrl #(.MISO_LAT(LAT), .GAP(GP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmd   (bus.slave),
        .SS_n  (SS_n),
        .MOSI  (MOSI),
        .MISO  (MISO)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // monitor / slave model state
    int          low_cnt = 0;
    int          high_cnt = 0;
    int          frames_done = 0;
    int          rsp_count = 0;
    int          rsp_high_pos = 0;
    int          mosi_extra_bad = 0;
    int          ready_bad = 0;
    logic [10:0] mosi_bits = '0;
    logic [7:0]  last_rsp_data = '0;
    logic        last_rsp_err = 1'b0;
    logic [10:0] flog [0:63];
    int          llog [0:63];
    int          hlog [0:63];
    logic [7:0]  slv_mem [0:255];
    logic [7:0]  slv_addr = '0;
    logic [7:0]  slv_byte;

    always @(negedge clk) begin
        if (SS_n === 1'b0) begin
            if (low_cnt == 0) begin
                if (frames_done < 64) hlog[frames_done] = high_cnt;
                high_cnt  = 0;
                mosi_bits = '0;
            end
            low_cnt++;
            if (low_cnt >= 2 && low_cnt <= 12) mosi_bits = {mosi_bits[9:0], MOSI};
            else if (MOSI !== 1'b0) mosi_extra_bad++;
            if (bus.cmd_ready !== 1'b0) ready_bad++;
            slv_byte = slv_mem[slv_addr];
            MISO = (low_cnt >= 15 && low_cnt <= 22) ? slv_byte[22-low_cnt] : 1'b0;
        end else begin
            if (low_cnt > 0) begin
                if (frames_done < 64) begin
                    llog[frames_done] = low_cnt;
                    flog[frames_done] = mosi_bits;
                end
                if (low_cnt == 12 || low_cnt == 22) begin
                    case (mosi_bits[9:8])
                        2'b00:   slv_addr = mosi_bits[7:0];
                        2'b01:   slv_mem[slv_addr] = mosi_bits[7:0];
                        2'b10:   slv_addr = mosi_bits[7:0];
                        default: ;
                    endcase
                end
                frames_done++;
            end
            low_cnt = 0;
            high_cnt++;
            MISO = 1'b0;
            if (MOSI !== 1'b0) mosi_extra_bad++;
        end
        if (bus.rsp_valid === 1'b1) begin
            rsp_count++;
            last_rsp_data = bus.rsp_data;
            last_rsp_err  = bus.rsp_err;
            rsp_high_pos  = high_cnt;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // step to just after the monitor has run on a falling edge
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] data);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        while (bus.cmd_ready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check("accept_timeout", (n < 300), 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check("ready_drop", bus.cmd_ready, 0);
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (rsp_count < target && n < 300) begin
            tick();
            n++;
        end
        check("rsp_timeout", (rsp_count >= target), 1);
    endtask

    int idx;
    int rc;

    initial begin
        for (int i = 0; i < 256; i++) slv_mem[i] = 8'h00;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 8'h00;

        // reset values
        #3 rst_n = 1'b0;
        #30;
        check("rst_ss_n", SS_n, 1);
        check("rst_mosi", MOSI, 0);
        check("rst_ready", bus.cmd_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_ready", bus.cmd_ready, 1);

`ifdef SPIM_SEQ_CHECK_EN
        idx = frames_done;
        rc  = rsp_count;
        send(2'b11, 8'h00);
        wait_rsp(rc + 1);
        tick();
        tick();
        check("seq_err", last_rsp_err, 1);
        check("seq_err_data", last_rsp_data, 8'h00);
        check("seq_no_frame", frames_done, idx);
        check("seq_ss_high", low_cnt, 0);
`endif

        // op 00, A5
        idx = frames_done;
        rc  = rsp_count;
        send(2'b00, 8'hA5);
        wait_rsp(rc + 1);
        check("wa_len", llog[idx], 12);
        check("wa_bits", flog[idx], 11'h0A5);
        check("wa_rsp_data", last_rsp_data, 8'h00);
        check("wa_rsp_err", last_rsp_err, 0);
        check("wa_rsp_first_gap", rsp_high_pos, 1);
        tick();
        check("wa_rsp_pulse", bus.rsp_valid, 0);

        // back-to-back op 01 3C then op 10 A5
        idx = frames_done;
        rc  = rsp_count;
        send(2'b01, 8'h3C);
        send(2'b10, 8'hA5);
        wait_rsp(rc + 2);
        tick();
        check("b2b_len0", llog[idx], 12);
        check("b2b_bits0", flog[idx], 11'h13C);
        check("b2b_len1", llog[idx+1], 12);
        check("b2b_bits1", flog[idx+1], 11'h6A5);
        check("b2b_gap_high", hlog[idx+1], GP + 1);
        check("b2b_slave_wr", slv_mem[8'hA5], 8'h3C);

        // read of 96 through the slave model
        rc = rsp_count;
        send(2'b00, 8'h20);
        send(2'b01, 8'h96);
        send(2'b10, 8'h20);
        idx = frames_done + 1;
        send(2'b11, 8'h00);
        wait_rsp(rc + 4);
        tick();
        check("rd_len", llog[idx], 12 + LAT + 8);
        check("rd_bits", flog[idx], 11'h700);
        check("rd_data", last_rsp_data, 8'h96);
        check("rd_err", last_rsp_err, 0);
        for (int i = 0; i < 4; i++) tick();
        check("rd_data_hold", bus.rsp_data, 8'h96);

        // reset during SHIFT bit 5 of an op 01 frame
        rc = rsp_count;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_data  = 8'h77;
        begin
            int n = 0;
            while (low_cnt != 7 && n < 300) begin
                tick();
                n++;
            end
            check("mid_reach_timeout", (n < 300), 1);
        end
        bus.cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_ss_async", SS_n, 1);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("mid_no_rsp", rsp_count, rc);
        check("mid_slave_untouched", slv_mem[8'h20], 8'h96);

        // full loop after reset
        rc = rsp_count;
        idx = frames_done;
        send(2'b00, 8'h10);
        send(2'b01, 8'h5A);
        send(2'b10, 8'h10);
        send(2'b11, 8'h00);
        wait_rsp(rc + 4);
        tick();
        check("loop_len0", llog[idx], 12);
        check("loop_bits0", flog[idx], 11'h010);
        check("loop_len3", llog[idx+3], 12 + LAT + 8);
        check("loop_data", last_rsp_data, 8'h5A);
        check("loop_err", last_rsp_err, 0);

        check("ready_in_frame", ready_bad, 0);
        check("mosi_idle_zero", mosi_extra_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
